rv32v_uop_sequencer: RTL and testbench

Parametrised micro-op sequencer for the rv32v pipeline. It replaces the fixed-geometry uop generator behind the vector control unit. It splits one decoded vector instruction into per-cycle uops across `NUM_LANES` lanes for any `VLEN`, element width and LMUL group, and supports `vstart` resume, back-to-back instructions and flush. It sits between vector decode and the vector register file / execute stage. It drives register offset, bank offset, uop index and per-lane active masks.

---
 rtl/rv32v_types_pkg.sv | 24 ++
 rtl/rv32v_lane_mask.sv | 27 ++
 rtl/rv32v_uop_sequencer.sv | 129 ++++++++++++
 tb/tb_rv32v_uop_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared rv32v vector types.
// Element widths, sequencer states and uop geometry helpers.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } vsew_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } uopseq_state_t;

  function automatic int unsigned uops_per_reg(
    vsew_t       sew,
    int unsigned vlen  = 128,
    int unsigned lanes = 4
  );
    return (vlen >> (3 + int'(sew))) / lanes;
  endfunction

endpackage

// File: rtl/rv32v_lane_mask.sv
// Per-lane element enable for one uop.
// Lane i is live when its element lies in [vstart, vl).
module rv32v_lane_mask #(
  parameter int NUM_LANES = 4,
  parameter int VL_W      = 8
) (
  input  logic                 en,
  input  logic [VL_W-1:0]      base,
  input  logic [VL_W-1:0]      vl,
  input  logic [VL_W-1:0]      vstart,
  output logic [NUM_LANES-1:0] active
);

  logic [VL_W:0] elem;

  always_comb begin
    active = '0;
    elem   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      elem      = {1'b0, base} + (VL_W+1)'(i);
      active[i] = en
                && (elem <  {1'b0, vl})
                && (elem >= {1'b0, vstart});
    end
  end

endmodule

// File: rtl/rv32v_uop_sequencer.sv
// Splits one vector instruction into per-cycle lane uops.
// Handles vstart resume, back-to-back issue and flush.
module rv32v_uop_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int VLEN      = 128,
  parameter int NUM_LANES = 4,
  parameter int VL_W      = $clog2(VLEN) + 1,
  parameter int UOP_W     = $clog2(VLEN/NUM_LANES) + 1,
  localparam int BANK_W   = $clog2(VLEN/8/NUM_LANES)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 gen,
  input  logic                 stall,
  input  logic                 flush,
  input  vsew_t                veew,
  input  logic [VL_W-1:0]      vl,
  input  logic [VL_W-1:0]      vstart,
  output logic                 busy,
  output logic                 vuop_valid,
  output logic                 vuop_last,
  output logic [UOP_W-1:0]     vuop_num,
  output logic [2:0]           vreg_offset,
  output logic [BANK_W-1:0]    vbank_offset,
  output logic [NUM_LANES-1:0] vlane_active
);

  localparam int LG      = $clog2(NUM_LANES);
  localparam int UPR8_LG = $clog2(VLEN/8/NUM_LANES);

  uopseq_state_t    state_q, state_d;
  logic [UOP_W-1:0] cnt_q, cnt_d;
  vsew_t            sew_q, sew_d;
  logic [VL_W-1:0]  vl_q, vl_d;
  logic [VL_W-1:0]  vs_q, vs_d;

  logic             take;
  logic             run;
  logic [UOP_W-1:0] first_in;
  logic [UOP_W-1:0] last_idx;
  logic [UOP_W-1:0] upr_m1;
  logic [UOP_W-1:0] vreg_full;
  int               slot_sh;

  assign take     = gen && (vl > vstart);
  assign first_in = UOP_W'(vstart >> LG);
  assign last_idx = UOP_W'((vl_q - VL_W'(1)) >> LG);
  assign run      = (state_q == RUN);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sew_q   <= SEW8;
      vl_q    <= '0;
      vs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sew_q   <= sew_d;
      vl_q    <= vl_d;
      vs_q    <= vs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sew_d   = sew_q;
    vl_d    = vl_q;
    vs_d    = vs_q;
    unique case (state_q)
      IDLE: begin
        if (take && !stall) begin
          state_d = RUN;
          cnt_d   = first_in;
          sew_d   = veew;
          vl_d    = vl;
          vs_d    = vstart;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cnt_q != last_idx) begin
            cnt_d = cnt_q + UOP_W'(1);
          end else if (take) begin
            cnt_d = first_in;
            sew_d = veew;
            vl_d  = vl;
            vs_d  = vstart;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Slot/register split: uops per register is a power of two per SEW
  assign upr_m1    = UOP_W'(uops_per_reg(sew_q, VLEN, NUM_LANES) - 1);
  assign slot_sh   = UPR8_LG - int'(sew_q);
  assign vreg_full = cnt_q >> slot_sh;

  assign busy         = run;
  assign vuop_valid   = run;
  assign vuop_last    = run && (cnt_q == last_idx);
  assign vuop_num     = run ? cnt_q : '0;
  assign vreg_offset  = run ? vreg_full[2:0] : '0;
  assign vbank_offset = run ? BANK_W'(cnt_q & upr_m1) : '0;

  rv32v_lane_mask #(
    .NUM_LANES (NUM_LANES),
    .VL_W      (VL_W)
  ) u_lane_mask (
    .en     (run),
    .base   (VL_W'(cnt_q) << LG),
    .vl     (vl_q),
    .vstart (vs_q),
    .active (vlane_active)
  );

endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Randomised + directed bench for rv32v_uop_sequencer.
// Reference model: queue of expected uops built from element arithmetic.
module tb_rv32v_uop_sequencer;
  import rv32v_types_pkg::*;

  localparam int VLEN   = 128;
  localparam int NL     = 4;
  localparam int VL_W   = $clog2(VLEN) + 1;
  localparam int UOP_W  = $clog2(VLEN/NL) + 1;
  localparam int BANK_W = $clog2(VLEN/8/NL);

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              gen = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  vsew_t             veew = SEW8;
  logic [VL_W-1:0]   vl = '0;
  logic [VL_W-1:0]   vstart = '0;
  logic              busy;
  logic              vuop_valid;
  logic              vuop_last;
  logic [UOP_W-1:0]  vuop_num;
  logic [2:0]        vreg_offset;
  logic [BANK_W-1:0] vbank_offset;
  logic [NL-1:0]     vlane_active;

  rv32v_uop_sequencer #(.VLEN(VLEN), .NUM_LANES(NL)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .gen          (gen),
    .stall        (stall),
    .flush        (flush),
    .veew         (veew),
    .vl           (vl),
    .vstart       (vstart),
    .busy         (busy),
    .vuop_valid   (vuop_valid),
    .vuop_last    (vuop_last),
    .vuop_num     (vuop_num),
    .vreg_offset  (vreg_offset),
    .vbank_offset (vbank_offset),
    .vlane_active (vlane_active)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int num;
    int vreg;
    int bank;
    int mask;
    bit last;
  } uop_t;

  uop_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_seq(int sew, int l, int vs);
    int epr, first, last, b, m;
    epr   = VLEN >> (3 + sew);
    first = vs / NL;
    last  = (l - 1) / NL;
    for (int n = first; n <= last; n++) begin
      uop_t u;
      b = n * NL;
      m = 0;
      for (int i = 0; i < NL; i++)
        if (b + i < l && b + i >= vs) m |= (1 << i);
      u.num  = n;
      u.vreg = (b / epr) % 8;
      u.bank = (b % epr) / NL;
      u.mask = m;
      u.last = (n == last);
      q.push_back(u);
    end
  endtask

  task automatic check_outputs();
    uop_t e;
    bit   v;
    v = (q.size() > 0);
    e = '{0, 0, 0, 0, 1'b0};
    if (v) e = q[0];
    chk("valid", 32'(vuop_valid), 32'(v));
    chk("busy", 32'(busy), 32'(v));
    chk("last", 32'(vuop_last), 32'(e.last));
    chk("num", 32'(vuop_num), e.num);
    chk("vreg", 32'(vreg_offset), e.vreg);
    chk("bank", 32'(vbank_offset), e.bank);
    chk("mask", 32'(vlane_active), e.mask);
  endtask

  task automatic step(bit g, bit s, bit f, int sew, int l, int vs);
    check_outputs();
    gen    = g;
    stall  = s;
    flush  = f;
    veew   = vsew_t'(sew);
    vl     = VL_W'(l);
    vstart = VL_W'(vs);
    if (f) begin
      q.delete();
    end else if (q.size() > 0) begin
      if (!s) begin
        void'(q.pop_front());
        if (q.size() == 0 && g && l > vs) push_seq(sew, l, vs);
      end
    end else if (g && !s && l > vs) begin
      push_seq(sew, l, vs);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int sew, l, vs;
    repeat (2) @(negedge CLK);
    check_outputs();
    nRST = 1'b1;
    @(negedge CLK);

    // 1: SEW32 vl=10
    step(1, 0, 0, 2, 10, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s1_mask", 32'(vlane_active), 32'h3);
    chk("s1_vreg", 32'(vreg_offset), 32'd2);
    idle(2);

    // 2: SEW8 vl=20
    step(1, 0, 0, 0, 20, 0);
    idle(3);
    chk("s2_bank", 32'(vbank_offset), 32'd3);
    step(0, 0, 0, 0, 0, 0);
    chk("s2_vreg", 32'(vreg_offset), 32'd1);
    chk("s2_last", 32'(vuop_last), 32'd1);
    idle(2);

    // 3: SEW16 vl=10 vstart=5
    step(1, 0, 0, 1, 10, 5);
    chk("s3_num", 32'(vuop_num), 32'd1);
    chk("s3_mask", 32'(vlane_active), 32'he);
    idle(3);

    // 4: stall 3 cycles on uop 1
    step(1, 0, 0, 2, 10, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("s4_hold", 32'(vuop_num), 32'd1);
    end
    idle(4);

    // 5: back-to-back, then flush mid-sequence
    step(1, 0, 0, 2, 8, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 40, 0);
    chk("s5_b2b", 32'(busy), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("s5_flush", 32'(vuop_valid), 32'd0);
    idle(2);

    // 6: no-op instructions, async reset mid-run
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 8, 8);
    chk("s6_noop", 32'(busy), 32'd0);
    step(1, 0, 0, 0, 64, 0);
    step(0, 0, 0, 0, 0, 0);
    gen = 1'b0;
    #2 nRST = 1'b0;
    #1 chk("s6_rst_valid", 32'(vuop_valid), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    #1 nRST = 1'b1;
    q.delete();
    @(posedge CLK);
    @(negedge CLK);
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      sew = $urandom_range(0, 2);
      l   = $urandom_range(0, VLEN >> sew);
      vs  = ($urandom_range(0, 3) != 0) ? $urandom_range(0, l)
                                        : $urandom_range(0, VLEN >> sew);
      step($urandom_range(0, 1), $urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0, sew, l, vs);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
